// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA 640x480@60 timing constants, FSM type and range helper
//
// Purpose: one home for the default display timing, so the controller and anything
//          that reasons about scan positions agree on the same numbers.
// Contents:
//   COLOR_W, CNT_W             colour channel width and scan-counter width
//   VGA_H_* / VGA_V_*          visible, porch and sync lengths (pixels / lines)
//   VGA_H_TOTAL / VGA_V_TOTAL  derived line and frame lengths (800 / 525)
//   VGA_HS_* / VGA_VS_*        inclusive sync pulse start/end positions
//   upd_state_e                vblank update handshake states
//   in_span()                  inclusive range test on a scan counter
package vga_timing_pkg;

   localparam int COLOR_W = 4;
   localparam int CNT_W   = 10;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;

   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
   localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

   typedef enum logic {
      UPD_IDLE = 1'b0,
      UPD_REQ  = 1'b1
   } upd_state_e;

   function automatic logic in_span(input logic [CNT_W-1:0] v, input int lo, input int hi);
      return (v >= CNT_W'(lo)) && (v <= CNT_W'(hi));
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - per-frame update handshake between VGA timing and game logic
//
// Purpose: groups the vblank update window handshake.
// Signals:
//   update_req   window open, held until acknowledged or the frame wraps
//   update_ack   game logic finished its per-frame update
//   frame_start  one-clk pulse when the scan wraps to (0,0)
//   overrun      sticky, an update missed its window
// Modports:
//   master  timing controller side (drives req/frame_start/overrun)
//   slave   game logic side (drives ack)
interface vga_timing_ctrl_if;

   logic update_req;
   logic update_ack;
   logic frame_start;
   logic overrun;

   modport master (
      output update_req,
      output frame_start,
      output overrun,
      input  update_ack
   );

   modport slave (
      input  update_req,
      input  frame_start,
      input  overrun,
      output update_ack
   );

endinterface

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// rtl/vga_timing_ctrl_pix_tick_gen.sv - CLK_DIV pixel enable divider
//
// Purpose: divides the system clock into a one-clk pixel enable.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   pix_tick_o   high for one clk every CLK_DIV clks (while the divider sits at CLK_DIV-1)
module pix_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_tick_o
);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (div_q == DIV_LAST) begin
         div_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // Divider restarts at 0 out of reset, so the first enable lands CLK_DIV clks later.
   assign pix_tick_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA scan counters, sync/colour output registers and vblank update handshake
//
// Purpose: runs the horizontal/vertical scan, produces registered active-low sync and
//          blanked colour, and opens one update window per frame for the game logic.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   rgb_in                {R,G,B} colour for the current hcount/vcount
//   pix_tick              one-clk pixel enable
//   hcount, vcount        current scan position
//   vgaRED/GREEN/BLUE     registered, blanked colour (one pixel behind the counters)
//   Hsync, Vsync          registered, active-low sync (one pixel behind the counters)
//   upd                   update_req/update_ack handshake, frame_start, overrun
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3*COLOR_W-1:0] rgb_in,
   output logic                 pix_tick,
   output logic [CNT_W-1:0]     hcount,
   output logic [CNT_W-1:0]     vcount,
   output logic [COLOR_W-1:0]   vgaRED,
   output logic [COLOR_W-1:0]   vgaGREEN,
   output logic [COLOR_W-1:0]   vgaBLUE,
   output logic                 Hsync,
   output logic                 Vsync,
   vga_timing_ctrl_if.master    upd
);

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_VIS  = CNT_W'(V_VISIBLE - 1);
   localparam logic [CNT_W-1:0] H_VIS_N     = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_N     = CNT_W'(V_VISIBLE);

   logic                 tick_w;
   logic [CNT_W-1:0]     hcount_q, hcount_d;
   logic [CNT_W-1:0]     vcount_q, vcount_d;
   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;
   upd_state_e           state_q, state_d;
   logic                 overrun_q, overrun_d;

   logic line_end;
   logic frame_wrap;
   logic vblank_entry;
   logic video_on;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_tick_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_tick_o (tick_w)
   );

   // Scan position events; all qualified by the pixel enable so they are one-clk pulses.
   // tick_w is low throughout reset, so reset itself never produces a frame_start.
   assign line_end     = (hcount_q == H_LAST);
   assign frame_wrap   = tick_w && line_end && (vcount_q == V_LAST);
   assign vblank_entry = tick_w && line_end && (vcount_q == V_LAST_VIS);
   assign video_on     = (hcount_q < H_VIS_N) && (vcount_q < V_VIS_N);

   // Scan counters
   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (tick_w) begin
         if (line_end) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
         end
      end
   end

   // Output registers: loaded from the decode of the position being left, which is
   // why sync and colour trail the counters by exactly one pixel period.
   always_comb begin
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      rgb_d   = rgb_q;
      if (tick_w) begin
         hsync_d = !in_span(hcount_q, HS_START, HS_END);
         vsync_d = !in_span(vcount_q, VS_START, VS_END);
         rgb_d   = video_on ? rgb_in : '0;
      end
   end

   // Update handshake. An ack in the same clk as the wrap takes priority, so a
   // just-in-time update is not reported as an overrun.
   always_comb begin
      state_d   = state_q;
      overrun_d = overrun_q;
      case (state_q)
         UPD_IDLE: begin
            if (vblank_entry) begin
               state_d = UPD_REQ;
            end
         end
         UPD_REQ: begin
            if (upd.update_ack) begin
               state_d = UPD_IDLE;
            end else if (frame_wrap) begin
               state_d   = UPD_IDLE;
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = UPD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcount_q  <= '0;
         vcount_q  <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         rgb_q     <= '0;
         state_q   <= UPD_IDLE;
         overrun_q <= 1'b0;
      end else begin
         hcount_q  <= hcount_d;
         vcount_q  <= vcount_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         rgb_q     <= rgb_d;
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   assign pix_tick        = tick_w;
   assign hcount          = hcount_q;
   assign vcount          = vcount_q;
   assign Hsync           = hsync_q;
   assign Vsync           = vsync_q;
   assign vgaRED          = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign vgaGREEN        = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign vgaBLUE         = rgb_q[COLOR_W-1   -: COLOR_W];
   assign upd.update_req  = (state_q == UPD_REQ);
   assign upd.frame_start = frame_wrap;
   assign upd.overrun     = overrun_q;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA display path of the snake design. It divides the 100 MHz board clock into a 25 MHz pixel enable and runs the 640x480@60 horizontal and vertical counters. It generates registered active-low Hsync/Vsync and blanks the 12-bit colour stream. Once per frame it offers the game logic a vertical-blanking update window through a req/ack handshake, and flags any update that overruns the window.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per pixel.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: Hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: Vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  100 MHz system clock. One clock domain; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- rgb_in  in  12  pixel colour {R,G,B}, 4 bits each, for the current hcount/vcount.
- update_ack  in  1  game logic has finished its per-frame state update.
- pix_tick  out  1  one-clk pulse every CLK_DIV cycles.
- hcount  out  10  current pixel column, 0..799.
- vcount  out  10  current line, 0..524.
- vgaRED, vgaGREEN, vgaBLUE  out  4 each  registered, blanked colour.
- Hsync, Vsync  out  1 each  registered, active-low sync.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).
- update_req  out  1  update window open; held until acknowledged.
- overrun  out  1  sticky; set when an update misses its window.

## Operation
- Divider: div counts 0..CLK_DIV-1. pix_tick=1 while div==CLK_DIV-1.
- Counters: hcount and vcount advance only on pix_tick.
  - hcount wraps at H_TOTAL-1=799 to 0. vcount increments on that wrap.
  - vcount wraps at V_TOTAL-1=524 to 0.
- Decode, from the current counters:
  - video_on = hcount<640 && vcount<480.
  - Hsync low for hcount in [656,751].
  - Vsync low for vcount in [490,491].
- Output register: on pix_tick, Hsync, Vsync and the colour outputs load from the decode.
  - Colour outputs load rgb_in if video_on, otherwise 0.
- Update handshake:
  - update_req sets on the pix_tick where (hcount,vcount) = (799,479), i.e. on entry to vblank.
  - While update_req=1, update_ack=1 clears update_req on the next clk edge.
  - update_ack while update_req=0 is ignored.
  - If update_req is still 1 on the frame_start cycle, update_req clears and overrun sets.
  - If update_ack and frame_start coincide, the ack wins: no overrun.
  - overrun clears only on reset.
- Reset values, all outputs: counters 0, div 0, pix_tick 0, Hsync 1, Vsync 1, colour 0, frame_start 0, update_req 0, overrun 0.
- Reset asserted mid-frame: every register returns to its reset value on the next clk edge.
  - Scan restarts at (0,0) one pixel period after rst_n deasserts.
  - No frame_start pulse is generated by the reset itself.

## Timing
- pix_tick period: exactly CLK_DIV clk cycles. The first pix_tick comes CLK_DIV cycles after rst_n rises.
- Latency: Hsync, Vsync and colour outputs lag the hcount/vcount they were decoded from by one pixel period.
  - The first Hsync low appears on the pix_tick after hcount==656.
- Line period: 800 pixel periods = 3200 clk. Frame period: 525 lines = 1,680,000 clk.
- Hsync low width: 96 pixel periods = 384 clk. Vsync low width: 2 lines = 6400 clk.
- frame_start: a single clk, coincident with the pix_tick that wraps (799,524) to (0,0).
- update_req: rises on the vblank-entry tick and falls one clk after the sampled ack. Ack latency is otherwise unbounded within the window.
- Available update window: 45 lines = 144,000 clk.

## Structure
- Shared package vga_timing_pkg holds:
  - H/V visible, porch and sync constants;
  - derived H_TOTAL=800, V_TOTAL=525;
  - sync start/end positions;
  - COLOR_W=4.
- One sub-module: pix_tick_gen, the CLK_DIV enable divider with sync reset.
- Everything else lives in vga_timing_ctrl: counters, decode, output registers, handshake FSM.
- Handshake FSM states:
  - IDLE → REQ at vblank entry.
  - REQ → IDLE on update_ack.
  - REQ → IDLE on frame_start, with overrun set.

## Test plan
- Reset check: hold rst_n=0 for 10 clk with rgb_in=12'hFFF → all outputs at their reset values. After release, pix_tick fires at clk 4, 8, 12, …
- Horizontal timing: one line → Hsync low for exactly 384 clk, starting one pixel period after hcount==656. Line period 3200 clk.
- Vertical and blanking: full frame with rgb_in=12'hABC →
  - colour outputs equal A/B/C only for 640x480 pixels, otherwise 0;
  - Vsync low for 6400 clk;
  - frame_start period 1,680,000 clk.
- Prompt ack: ack 100 clk after update_req rises → update_req falls the next clk; overrun stays 0.
- Missed ack: never ack → update_req falls on frame_start; overrun=1 and remains 1 across following frames until rst_n=0.
- Ack on the frame_start cycle gives overrun=0. Asserting rst_n=0 at (hcount,vcount)=(300,200) restarts the scan at (0,0) with no spurious frame_start.
